// File: rtl/sync_fifo_stream_packer.sv
// ============================================================================
// sync_fifo_stream_packer
// ----------------------------------------------------------------------------
// Purpose:
//   Packs PACK_RATIO consecutive DATA_WIDTH words from a valid/ready stream
//   into one wide word with a per-lane keep mask. Lane 0 is the first word
//   accepted and sits at the LSBs. A partial word is sealed early by in_last,
//   and, when PACKER_TIMEOUT_EN is defined, by TIMEOUT_CYCLES idle cycles.
//   The packer holds one accumulator and one output register. This lets it
//   accept one narrow word every cycle, with no bubble when a word moves from
//   the accumulator to the output register.
//
// Optional feature macro:
//   PACKER_TIMEOUT_EN  enables the idle-timeout flush of partial words.
//
// Ports:
//   clk        in   1                      single clock, posedge
//   rst        in   1                      synchronous, active-high reset
//   in_data    in   DATA_WIDTH             narrow word
//   in_valid   in   1                      narrow word valid
//   in_ready   out  1                      narrow word can be accepted
//   in_last    in   1                      narrow word closes a packet
//   out_data   out  DATA_WIDTH*PACK_RATIO  packed word
//   out_keep   out  PACK_RATIO             per-lane valid mask
//   out_valid  out  1                      packed word valid
//   out_ready  in   1                      consumer accepts packed word
//   out_last   out  1                      packed word ends a packet
//   clear      in   1                      synchronous flush, data discarded
//   fill       out  LB_PACK_RATIO+1        lanes held in the accumulator
// ============================================================================
module sync_fifo_stream_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PACK_RATIO     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_keep,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    input  logic                             clear,
    output logic [$clog2(PACK_RATIO):0]      fill
);

    localparam int LB_PACK_RATIO = $clog2(PACK_RATIO);
    localparam int CW            = LB_PACK_RATIO + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(PACK_RATIO);

    logic [DATA_WIDTH-1:0]            acc_lane [PACK_RATIO];
    logic [CW-1:0]                    acc_cnt;
    logic                             acc_last;
    logic                             acc_sealed;

    logic                             in_exec;
    logic                             out_exec;
    logic                             move;
    logic                             timeout_hit;
    logic [CW-1:0]                    base_cnt;
    logic [CW-1:0]                    next_cnt;
    logic [LB_PACK_RATIO-1:0]         wr_lane;
    logic [DATA_WIDTH*PACK_RATIO-1:0] packed_data;
    logic [PACK_RATIO-1:0]            packed_keep;

    // A sealed accumulator blocks input only while the output register is
    // occupied and not being drained this cycle.
    assign in_ready = !acc_sealed || !out_valid || out_ready;
    assign in_exec  = in_valid && in_ready;
    assign out_exec = out_valid && out_ready;
    assign move     = acc_sealed && (!out_valid || out_ready);

    // On a move the accumulator empties in the same cycle, so a word accepted
    // alongside it starts a fresh word in lane 0.
    assign base_cnt = move ? '0 : acc_cnt;
    assign next_cnt = base_cnt + 1'b1;
    assign wr_lane  = base_cnt[LB_PACK_RATIO-1:0];
    assign fill     = acc_cnt;

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        packed_data = '0;
        packed_keep = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            if (CW'(i) < acc_cnt) begin
                packed_data[i*DATA_WIDTH +: DATA_WIDTH] = acc_lane[i];
                packed_keep[i]                          = 1'b1;
            end
        end
    end

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          idle_tick;

    // Idle counting only applies to a started, still-open word.
    assign idle_tick   = (acc_cnt != '0) && !acc_sealed && !in_exec;
    assign timeout_hit = idle_tick && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idle_cnt <= '0;
        end else if (!idle_tick || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_cnt    <= '0;
            acc_sealed <= 1'b0;
            acc_last   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
        end else begin
            if (move) begin
                out_data  <= packed_data;
                out_keep  <= packed_keep;
                out_last  <= acc_last;
                out_valid <= 1'b1;
            end else if (out_exec) begin
                out_valid <= 1'b0;
            end

            if (in_exec) begin
                acc_cnt    <= next_cnt;
                acc_sealed <= (next_cnt == FULL_CNT) || in_last;
                acc_last   <= in_last;
            end else if (move) begin
                acc_cnt    <= '0;
                acc_sealed <= 1'b0;
                acc_last   <= 1'b0;
            end else if (timeout_hit) begin
                acc_sealed <= 1'b1;
                acc_last   <= 1'b0;
            end
        end
    end

    // NOTE: lane storage is not reset; lanes at or above acc_cnt are masked to
    // zero when the word is packed, so stale contents never reach out_data.
    always_ff @(posedge clk) begin
        if (in_exec && !(rst || clear)) begin
            acc_lane[wr_lane] <= in_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo_stream_packer.sv
module tb_sync_fifo_stream_packer;

    localparam int DW = 8;
    localparam int PR = 4;
    localparam int OW = DW * PR;
    localparam int FW = $clog2(PR) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [OW-1:0] out_data;
    logic [PR-1:0] out_keep;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [FW-1:0] fill;

    sync_fifo_stream_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .clear(clear), .fill(fill)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: accepted narrow words are grouped into packed words by
    // the packing rules (full group of PR or closed by in_last).
    // ------------------------------------------------------------------
    typedef struct {
        logic [OW-1:0] d;
        logic [PR-1:0] k;
        logic          l;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] grp[$];
    word_t         sb_w;
    int            acc_words = 0;
    int            out_words = 0;
    bit            mon_en    = 1'b1;

    always @(negedge clk) begin
        if (rst || clear) begin
            exp_q.delete();
            grp.delete();
        end else if (mon_en) begin
            if (out_valid && out_ready) begin
                out_words++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_extra: got word %0h keep %0h, required no word", out_data, out_keep);
                end else begin
                    sb_w = exp_q.pop_front();
                    check("sb_data", out_data, sb_w.d);
                    check("sb_keep", out_keep, sb_w.k);
                    check("sb_last", out_last, sb_w.l);
                end
            end
            if (in_valid && in_ready) begin
                acc_words++;
                grp.push_back(in_data);
                if (grp.size() == PR || in_last) begin
                    sb_w.d = '0;
                    for (int i = 0; i < grp.size(); i++) sb_w.d = sb_w.d | (OW'(grp[i]) << (i * DW));
                    sb_w.k = PR'((1 << grp.size()) - 1);
                    sb_w.l = in_last;
                    exp_q.push_back(sb_w);
                    grp.delete();
                end
            end
        end
    end

    // Drive one word and hold it until accepted (bounded wait).
    task automatic push(input logic [DW-1:0] d, input logic l);
        int n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_wait: in_ready 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_keep"}, out_keep, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_fill"}, fill, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Table: inputs applied for one cycle; expected values are the outputs
    // seen before the edge that consumes those inputs.
    typedef struct {
        logic [DW-1:0] d;
        logic          v;
        logic          l;
        logic          ev;
        logic [OW-1:0] edata;
        logic [PR-1:0] ekeep;
        logic          elast;
        logic [FW-1:0] efill;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  obase;
        int  n;
        int  gap;
        int  cyc;
        bit  seen;
        logic v;

        vecs[0]  = '{8'h01, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd0};
        vecs[1]  = '{8'h02, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd1};
        vecs[2]  = '{8'h03, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd2};
        vecs[3]  = '{8'h04, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd3};
        vecs[4]  = '{8'h05, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd4};
        vecs[5]  = '{8'h06, 1'b1, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 3'd1};
        vecs[6]  = '{8'h07, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd2};
        vecs[7]  = '{8'h08, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd3};
        vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd4};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 1'b1, 32'h08070605, 4'hF, 1'b0, 3'd0};
        vecs[10] = '{8'hA1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd0};
        vecs[11] = '{8'hA2, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd1};
        vecs[12] = '{8'hA3, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 3'd2};
        vecs[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd3};
        vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b1, 32'h00A3A2A1, 4'h7, 1'b1, 3'd0};
        vecs[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd0};

        rst       = 1'b1;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;

        // Tests 1 and 2: full words back to back, then a 3-lane last word.
        for (int i = 0; i < 16; i++) begin
            in_data  = vecs[i].d;
            in_valid = vecs[i].v;
            in_last  = vecs[i].l;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
            check($sformatf("vec%0d_fill", i), fill, vecs[i].efill);
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_data", i), out_data, vecs[i].edata);
                check($sformatf("vec%0d_keep", i), out_keep, vecs[i].ekeep);
                check($sformatf("vec%0d_last", i), out_last, vecs[i].elast);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Test 3: backpressure, 12 words with out_ready low.
        out_ready = 1'b0;
        base      = acc_words;
        obase     = out_words;
        fork
            begin
                for (int k = 0; k < 12; k++) push(DW'(8'h40 + k), 1'b0);
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (out_valid) check("bp_hold_data", out_data, 32'h43424140);
                end
                check("bp_accepted", acc_words - base, 8);
                check("bp_in_ready", in_ready, 0);
                check("bp_valid", out_valid, 1);
                check("bp_keep", out_keep, 4'hF);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("bp_words_out", out_words - obase, 3);
        check("bp_sb_empty", exp_q.size(), 0);

        // Test 4: clear mid-word.
        push(8'h20, 1'b0);
        push(8'h21, 1'b0);
        @(negedge clk);
        check("pre_clear_fill", fill, 2);
        @(posedge clk);
        #1;
        in_data  = 8'hEE;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("clear_fill", fill, 0);
        check("clear_valid", out_valid, 0);
        check("clear_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) push(DW'(8'h30 + k), 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("post_clear_valid", out_valid, 1);
        check("post_clear_data", out_data, 32'h33323130);
        check("post_clear_keep", out_keep, 4'hF);
        @(posedge clk);
        #1;

        // Test 5: idle timeout on a single-lane partial word.
`ifdef PACKER_TIMEOUT_EN
        mon_en = 1'b0;
        push(8'h55, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        check("to_valid", out_valid, 1);
        check("to_data", out_data, 32'h00000055);
        check("to_keep", out_keep, 4'h1);
        check("to_last", out_last, 0);
        // 16 idle cycles seal the word; it moves to the output one cycle later.
        check("to_window", (n >= 16 && n <= 18), 1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        mon_en = 1'b1;
`else
        push(8'h55, 1'b0);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_timeout_out", seen, 0);
        check("no_timeout_fill", fill, 1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
`endif

        // Test 6: random traffic against the scoreboard, with one mid-stream reset.
        base = acc_words;
        gap  = 0;
        cyc  = 0;
        while ((acc_words - base) < 10000 && cyc < 60000) begin
            cyc++;
            if (cyc == 5000) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check_reset_values("mid_rst");
                @(posedge clk);
                #1;
            end
            v         = ($urandom_range(0, 99) < 70) || (gap >= 8);
            gap       = v ? 0 : gap + 1;
            in_valid  = v;
            in_data   = DW'($urandom);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 99) < 60);
            @(posedge clk);
            #1;
        end
        check("rnd_word_count", (acc_words - base) >= 10000, 1);
        out_ready = 1'b1;
        push(8'hFF, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("rnd_sb_empty", exp_q.size(), 0);
        check("rnd_grp_empty", grp.size(), 0);
        check("rnd_final_fill", fill, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
